// File: rtl/apb2_master_ctrl.sv
// APB2 bus master: buffers valid/ready commands in a small FIFO and replays them
// as SETUP/ACCESS transfers, returning read data on a one-slot response channel.
//   state  | meaning
//   IDLE   | bus idle, waiting for an issuable FIFO head
//   SETUP  | pselx=1, penable=0, address phase
//   ACCESS | pselx=1, penable=1, data phase (prdata sampled on exit)
module apb2_master_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic                  fifo_write_q [FIFO_DEPTH];
    logic                  fifo_write_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_d  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic push, pop, fifo_empty, capture, slot_free, can_issue;

    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = (count_q != FULL_CNT);
    assign push       = cmd_valid & cmd_ready;
    assign capture    = (state_q == ACCESS) & ~pwrite_q;
    // A read leaving ACCESS refills the slot this edge, so a following read must wait.
    assign slot_free  = (~rsp_valid_q | rsp_ready) & ~capture;
    assign can_issue  = ~fifo_empty & (fifo_write_q[rd_ptr_q] | slot_free);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = SETUP;
                    pop     = 1'b1;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (can_issue) begin
                    state_d = SETUP;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_write_d = fifo_write_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_wdata_d = fifo_wdata_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (push) begin
            fifo_write_d[wr_ptr_q] = cmd_write;
            fifo_addr_d[wr_ptr_q]  = cmd_addr;
            fifo_wdata_d[wr_ptr_q] = cmd_wdata;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (pop) begin
            pwrite_d = fifo_write_q[rd_ptr_q];
            paddr_d  = fifo_addr_q[rd_ptr_q];
            pwdata_d = fifo_wdata_q[rd_ptr_q];
        end
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = prdata;
        end else if (rsp_valid_q & rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_write_q[i] <= 1'b0;
                fifo_addr_q[i]  <= '0;
                fifo_wdata_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            fifo_write_q <= fifo_write_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_wdata_q <= fifo_wdata_d;
        end
    end

    assign pselx     = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_apb2_master_ctrl.sv
// Bench for apb2_master_ctrl: directed scenarios plus a random phase, all checked
// against a queue-based model of pending commands and the single response slot.
module tb_apb2_master_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          pclk = 1'b0;
    logic          preset = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          busy, pselx, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;

    always #5 pclk = ~pclk;

    apb2_master_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .pselx(pselx), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
    );

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    cmd_t          q[$];
    bit            exp_rv;
    logic [DW-1:0] exp_rd;
    bit            cur_write;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    int            vectors = 0;
    int            miscompares = 0;
    bit            last_pushed;
    bit            prdata_fixed = 0;
    bit            tr_psel[$];
    bit            tr_pen[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 idle, 1 setup, 2 access, 3 illegal
    function automatic int phase_of();
        return (pselx === 1'b1) ? ((penable === 1'b1) ? 2 : 1) : ((penable === 1'b1) ? 3 : 0);
    endfunction

    task automatic model_clear();
        q.delete();
        exp_rv    = 0;
        exp_rd    = '0;
        cur_write = 0;
        cur_addr  = '0;
        cur_wdata = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pselx"}, pselx, 0);
        chk({tag, "_penable"}, penable, 0);
        chk({tag, "_pwrite"}, pwrite, 0);
        chk({tag, "_paddr"}, paddr, 0);
        chk({tag, "_pwdata"}, pwdata, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    // One clock: predict from spec rules with the pre-edge view, then compare at edge+1.
    task automatic tick();
        int            ph, ph_exp, ph2;
        bit            slot_free, head_ok, capture, pushed;
        cmd_t          c;
        ph        = phase_of();
        pushed    = cmd_valid && (q.size() < DEPTH);
        c.w       = cmd_write;
        c.a       = cmd_addr;
        c.d       = cmd_wdata;
        capture   = (ph == 2) && !cur_write;
        slot_free = (!exp_rv || rsp_ready) && !capture;
        head_ok   = (q.size() != 0) && (q[0].w || slot_free);
        case (ph)
            0:       ph_exp = head_ok ? 1 : 0;
            1:       ph_exp = 2;
            2:       ph_exp = head_ok ? 1 : 0;
            default: ph_exp = 0;
        endcase
        if (capture) begin
            exp_rv = 1;
            exp_rd = prdata;
        end else if (exp_rv && rsp_ready) begin
            exp_rv = 0;
        end
        @(posedge pclk);
        #1;
        ph2 = phase_of();
        chk("phase", ph2, ph_exp);
        if (ph2 == 1) begin
            chk("issue_from_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                c = q.pop_front();
                cur_write = c.w;
                cur_addr  = c.a;
                cur_wdata = c.d;
                c.w = cmd_write;
                c.a = cmd_addr;
                c.d = cmd_wdata;
            end
        end
        chk("paddr", paddr, cur_addr);
        chk("pwrite", pwrite, cur_write);
        chk("pwdata", pwdata, cur_wdata);
        if (pushed) q.push_back(c);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("busy", busy, (q.size() != 0) || (ph2 != 0));
        chk("cmd_ready", cmd_ready, q.size() < DEPTH);
        last_pushed = pushed;
        tr_psel.push_back(pselx);
        tr_pen.push_back(penable);
        if (!prdata_fixed) prdata = $urandom;
    endtask

    task automatic push_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        last_pushed = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_pushed) break;
        end
        chk("push_accepted", last_pushed, 1);
        cmd_valid = 0;
    endtask

    task automatic drain();
        cmd_valid = 0;
        rsp_ready = 1;
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && pselx !== 1'b1) break;
            tick();
        end
        chk("drain_done", (q.size() == 0) && (pselx === 1'b0), 1);
        tick();
    endtask

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1; prdata = '0;
        model_clear();

        // Reset values
        #1 preset = 1;
        #1 check_reset_outputs("reset");
        @(posedge pclk); @(posedge pclk); #1;
        preset = 0;

        // Single write
        push_cmd(1, 32'h10, 32'hDEADBEEF);
        tick();
        chk("wr_setup_psel", pselx, 1);
        chk("wr_setup_pen", penable, 0);
        chk("wr_setup_pwrite", pwrite, 1);
        chk("wr_setup_paddr", paddr, 32'h10);
        chk("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
        tick();
        chk("wr_access_pen", penable, 1);
        tick();
        chk("wr_done_psel", pselx, 0);
        chk("wr_done_busy", busy, 0);
        chk("wr_no_rsp", rsp_valid, 0);

        // Single read, 3-cycle latency
        prdata_fixed = 1;
        prdata = 32'hA5A5A5A5;
        rsp_ready = 0;
        push_cmd(0, 32'h20, $urandom);
        tick();
        chk("rd_setup_paddr", paddr, 32'h20);
        tick();
        chk("rd_e2_no_rsp", rsp_valid, 0);
        tick();
        chk("rd_e3_rsp_valid", rsp_valid, 1);
        chk("rd_e3_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);
        rsp_ready = 1;
        tick();
        chk("rd_rsp_cleared", rsp_valid, 0);
        prdata_fixed = 0;
        drain();

        // Back-to-back writes
        tr_psel.delete();
        tr_pen.delete();
        for (int i = 0; i < 5; i++) push_cmd(1, 32'h100 + 4 * i, $urandom);
        drain();
        chk("b2b_trace_len", tr_psel.size() >= 12, 1);
        if (tr_psel.size() >= 12) begin
            for (int i = 1; i <= 10; i++) begin
                chk("b2b_psel", tr_psel[i], 1);
                chk("b2b_penable", tr_pen[i], (i % 2) == 0);
            end
            chk("b2b_end_psel", tr_psel[11], 0);
        end

        // Response backpressure and FIFO full
        rsp_ready = 0;
        push_cmd(0, 32'h0, $urandom);
        push_cmd(0, 32'h4, $urandom);
        push_cmd(1, 32'h8, $urandom);
        push_cmd(1, 32'hC, $urandom);
        push_cmd(1, 32'h10, $urandom);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h14; cmd_wdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_full_ready", cmd_ready, 0);
            chk("bp_bus_idle", pselx, 0);
            chk("bp_rsp_held", rsp_valid, 1);
        end
        rsp_ready = 1;
        tick();
        chk("bp_release_psel", pselx, 1);
        chk("bp_release_pen", penable, 0);
        chk("bp_release_paddr", paddr, 32'h4);
        chk("bp_release_rsp", rsp_valid, 0);
        rsp_ready = 0;
        push_cmd(1, 32'h14, cmd_wdata);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid = $urandom_range(0, 1);
            cmd_write = $urandom_range(0, 1);
            cmd_addr  = $urandom & 32'hFFFF_FFFC;
            cmd_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset during ACCESS with two queued
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200 + 4 * i; cmd_wdata = $urandom;
            tick();
        end
        chk("mid_in_access", penable, 1);
        chk("mid_busy", busy, 1);
        #2 preset = 1;
        #1 check_reset_outputs("midreset");
        model_clear();
        cmd_valid = 0;
        @(posedge pclk); #1;
        preset = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("post_reset_idle", pselx, 0);
        chk("post_reset_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
